// File: rtl/dcw_sequencer.sv
// Reconfiguration sequencer for the data channel wrapper: reset, program clock increments, settle, run.
// Optional one-entry request buffer enabled by DCW_SEQ_PENDING_EN.
//
// state  | meaning
// IDLE   | waiting for a request; wrapper outputs hold their last values
// RST    | channel held in reset for RESET_CYCLES cycles
// CLK    | one cycle: clock increment pair programmed
// SETTLE | SETTLE_CYCLES cycles for the reference clock to settle
// RUN    | one cycle: channel released with the selected width, done pulses
module dcw_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int CLW           = 25
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_width,
  input  logic [2:0]     cfg_alt_width,
  input  logic           cfg_use_alt,
  input  logic [CLW-1:0] cfg_clk_want,
  input  logic [CLW-1:0] cfg_clk_base,
  input  logic           abort,
  output logic [2:0]     ctrl_sig,
  output logic [2:0]     val,
  output logic [2:0]     val1,
  output logic [CLW-1:0] wanted_cl_val,
  output logic [CLW-1:0] earlier_cl_val,
  output logic           busy,
  output logic           done,
  output logic           aborted
);

  localparam int MAXC = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_CLK, S_SETTLE, S_RUN} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [2:0]     hold_width, hold_alt;
  logic           hold_use_alt;
  logic [CLW-1:0] hold_want, hold_base;

  logic           launch, do_abort;
  logic [2:0]     src_width, src_alt;
  logic           src_use_alt;
  logic [CLW-1:0] src_want, src_base;

`ifdef DCW_SEQ_PENDING_EN
  logic           pend_valid;
  logic [2:0]     pend_width, pend_alt;
  logic           pend_use_alt;
  logic [CLW-1:0] pend_want, pend_base;
  logic           accept, store;

  // A waiting entry always launches ahead of any new request.
  always_comb begin
    cfg_ready   = !pend_valid;
    accept      = cfg_valid && cfg_ready;
    store       = accept && (state != S_IDLE);
    launch      = (state == S_IDLE) && (pend_valid || accept);
    src_width   = pend_valid ? pend_width   : cfg_width;
    src_alt     = pend_valid ? pend_alt     : cfg_alt_width;
    src_use_alt = pend_valid ? pend_use_alt : cfg_use_alt;
    src_want    = pend_valid ? pend_want    : cfg_clk_want;
    src_base    = pend_valid ? pend_base    : cfg_clk_base;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_valid   <= 1'b0;
      pend_width   <= '0;
      pend_alt     <= '0;
      pend_use_alt <= 1'b0;
      pend_want    <= '0;
      pend_base    <= '0;
    end else if (store) begin
      pend_valid   <= 1'b1;
      pend_width   <= cfg_width;
      pend_alt     <= cfg_alt_width;
      pend_use_alt <= cfg_use_alt;
      pend_want    <= cfg_clk_want;
      pend_base    <= cfg_clk_base;
    end else if (launch) begin
      pend_valid <= 1'b0;
    end
  end
`else
  always_comb begin
    cfg_ready   = (state == S_IDLE);
    launch      = cfg_valid && cfg_ready;
    src_width   = cfg_width;
    src_alt     = cfg_alt_width;
    src_use_alt = cfg_use_alt;
    src_want    = cfg_clk_want;
    src_base    = cfg_clk_base;
  end
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    do_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) begin
          state_nx = S_RST;
          cnt_nx   = '0;
        end
      end
      S_RST: begin
        if (abort) begin
          state_nx = S_IDLE;
          do_abort = 1'b1;
        end else if (cnt == RST_LAST) begin
          state_nx = S_CLK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_CLK: begin
        if (abort) begin
          state_nx = S_IDLE;
          do_abort = 1'b1;
        end else begin
          state_nx = S_SETTLE;
          cnt_nx   = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_nx = S_IDLE;
          do_abort = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_nx = S_RUN;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_RUN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      hold_width     <= '0;
      hold_alt       <= '0;
      hold_use_alt   <= 1'b0;
      hold_want      <= '0;
      hold_base      <= '0;
      ctrl_sig       <= 3'd1;
      val            <= '0;
      val1           <= '0;
      wanted_cl_val  <= '0;
      earlier_cl_val <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      busy    <= (state_nx != S_IDLE);
      done    <= (state_nx == S_RUN);
      aborted <= do_abort;
      if (launch) begin
        hold_width   <= src_width;
        hold_alt     <= src_alt;
        hold_use_alt <= src_use_alt;
        hold_want    <= src_want;
        hold_base    <= src_base;
        val          <= src_width;
        val1         <= src_alt;
        ctrl_sig     <= 3'd1;
      end
      if (state_nx == S_CLK) begin
        wanted_cl_val  <= hold_want;
        earlier_cl_val <= hold_base;
      end
      if (state_nx == S_RUN)
        ctrl_sig <= hold_use_alt ? 3'd3 : 3'd2;
    end
  end

endmodule

// File: tb/tb_dcw_sequencer.sv
// Scoreboard bench for dcw_sequencer with RESET_CYCLES=4, SETTLE_CYCLES=8.
module tb_dcw_sequencer;
  localparam int RC  = 4;
  localparam int SC  = 8;
  localparam int CLW = 25;
  localparam int LAT = RC + 1 + SC + 1;
`ifdef DCW_SEQ_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset_n, cfg_valid, cfg_ready, cfg_use_alt, abort;
  logic [2:0]     cfg_width, cfg_alt_width, ctrl_sig, val, val1;
  logic [CLW-1:0] cfg_clk_want, cfg_clk_base, wanted_cl_val, earlier_cl_val;
  logic           busy, done, aborted;

  dcw_sequencer #(.RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .CLW(CLW)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_width(cfg_width), .cfg_alt_width(cfg_alt_width), .cfg_use_alt(cfg_use_alt),
    .cfg_clk_want(cfg_clk_want), .cfg_clk_base(cfg_clk_base), .abort(abort),
    .ctrl_sig(ctrl_sig), .val(val), .val1(val1), .wanted_cl_val(wanted_cl_val),
    .earlier_cl_val(earlier_cl_val), .busy(busy), .done(done), .aborted(aborted));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit             kind;  // 0 = done, 1 = aborted
    int             at;
    logic [2:0]     ctrl, v, v1;
    logic [CLW-1:0] want, base;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit k, input int at, input logic [2:0] c, input logic [2:0] v,
                      input logic [2:0] v1, input logic [CLW-1:0] w, input logic [CLW-1:0] b);
    exp_t e;
    e.kind = k; e.at = at; e.ctrl = c; e.v = v; e.v1 = v1; e.want = w; e.base = b;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and returns the accept-edge cycle number; inputs are scrambled afterwards.
  task automatic req(input logic [2:0] w, input logic [2:0] alt, input logic ua,
                     input logic [CLW-1:0] want, input logic [CLW-1:0] base, output int a);
    cfg_width = w; cfg_alt_width = alt; cfg_use_alt = ua;
    cfg_clk_want = want; cfg_clk_base = base; cfg_valid = 1'b1;
    chk("ready_before_accept", 32'(cfg_ready), 32'd1);
    tick();
    a = cyc;
    cfg_valid = 1'b0;
    cfg_width = ~w; cfg_alt_width = ~alt; cfg_use_alt = ~ua;
    cfg_clk_want = ~want; cfg_clk_base = ~base;
  endtask

  // Monitor: every done/aborted pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1 && aborted === 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL done_and_aborted: both high at cycle %0d", cyc);
    end else if (done === 1'b1 || aborted === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: done=%0b aborted=%0b at cycle %0d, none expected", done, aborted, cyc);
      end else begin
        e = sb.pop_front();
        if (aborted !== e.kind || cyc != e.at || ctrl_sig !== e.ctrl || val !== e.v ||
            val1 !== e.v1 || wanted_cl_val !== e.want || earlier_cl_val !== e.base) begin
          n_errors++;
          $display("FAIL pulse_match: got kind=%0b cyc=%0d ctrl=%0d val=%0d val1=%0d want=%0h base=%0h expected kind=%0b cyc=%0d ctrl=%0d val=%0d val1=%0d want=%0h base=%0h",
                   aborted, cyc, ctrl_sig, val, val1, wanted_cl_val, earlier_cl_val,
                   e.kind, e.at, e.ctrl, e.v, e.v1, e.want, e.base);
        end
      end
    end
  end

  initial begin
    int a;
    reset_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0; cfg_use_alt = 1'b0;
    cfg_width = '0; cfg_alt_width = '0; cfg_clk_want = '0; cfg_clk_base = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_ctrl", 32'(ctrl_sig), 32'd1);
    chk("rst_val", 32'(val), 32'd0);
    chk("rst_val1", 32'(val1), 32'd0);
    chk("rst_want", 32'(wanted_cl_val), 32'd0);
    chk("rst_base", 32'(earlier_cl_val), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic primary-width sequence
    req(3'd5, 3'd2, 1'b0, 25'h100000, 25'h080000, a);
    push(1'b0, a + LAT - 1, 3'd2, 3'd5, 3'd2, 25'h100000, 25'h080000);
    chk("basic_rst_ctrl", 32'(ctrl_sig), 32'd1);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_ready_busy", 32'(cfg_ready), 32'(PEND));
    chk("basic_val", 32'(val), 32'd5);
    chk("basic_val1", 32'(val1), 32'd2);
    repeat (3) tick();
    chk("basic_want_before_clk", 32'(wanted_cl_val), 32'd0);
    tick();
    chk("basic_want_at_clk", 32'(wanted_cl_val), 32'h100000);
    chk("basic_base_at_clk", 32'(earlier_cl_val), 32'h080000);
    chk("basic_ctrl_at_clk", 32'(ctrl_sig), 32'd1);
    repeat (8) tick();
    chk("basic_ctrl_last_settle", 32'(ctrl_sig), 32'd1);
    chk("basic_done_not_early", 32'(done), 32'd0);
    tick();
    chk("basic_ctrl_run", 32'(ctrl_sig), 32'd2);
    tick();
    chk("basic_ready_after", 32'(cfg_ready), 32'd1);
    chk("basic_busy_after", 32'(busy), 32'd0);
    chk("basic_ctrl_held", 32'(ctrl_sig), 32'd2);

    // Alternate width, equal want/base still runs the full settle
    req(3'd5, 3'd2, 1'b1, 25'h1ABCDE, 25'h1ABCDE, a);
    push(1'b0, a + LAT - 1, 3'd3, 3'd5, 3'd2, 25'h1ABCDE, 25'h1ABCDE);
    repeat (LAT) tick();
    chk("alt_ctrl_idle", 32'(ctrl_sig), 32'd3);
    repeat (3) tick();
    chk("alt_ctrl_held", 32'(ctrl_sig), 32'd3);
    chk("alt_val1_held", 32'(val1), 32'd2);

    // Abort during SETTLE (cycle 8 after accept)
    req(3'd5, 3'd2, 1'b0, 25'h100000, 25'h080000, a);
    push(1'b1, a + 8, 3'd1, 3'd5, 3'd2, 25'h100000, 25'h080000);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ctrl", 32'(ctrl_sig), 32'd1);
    chk("abort_want_kept", 32'(wanted_cl_val), 32'h100000);
    chk("abort_ready", 32'(cfg_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (15) tick();

    // Abort while idle does nothing
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    chk("idle_abort_ready", 32'(cfg_ready), 32'd1);

    // Abort during RST: clock values untouched
    req(3'd1, 3'd1, 1'b0, 25'h000123, 25'h000456, a);
    push(1'b1, a + 2, 3'd1, 3'd1, 3'd1, 25'h100000, 25'h080000);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rst_base_kept", 32'(earlier_cl_val), 32'h080000);
    repeat (3) tick();

    // Abort during RUN is ignored
    req(3'd6, 3'd3, 1'b1, 25'h0000AA, 25'h0000BB, a);
    push(1'b0, a + LAT - 1, 3'd3, 3'd6, 3'd3, 25'h0000AA, 25'h0000BB);
    repeat (LAT - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("run_abort_ctrl", 32'(ctrl_sig), 32'd3);

    // Busy rejection (or pending launch when the buffer is built in)
    req(3'd1, 3'd6, 1'b0, 25'h5, 25'h3, a);
    push(1'b0, a + LAT - 1, 3'd2, 3'd1, 3'd6, 25'h5, 25'h3);
    cfg_width = 3'd4; cfg_alt_width = 3'd0; cfg_use_alt = 1'b1;
    cfg_clk_want = 25'h7; cfg_clk_base = 25'h9; cfg_valid = 1'b1;
    if (PEND) push(1'b0, a + 2 * LAT, 3'd3, 3'd4, 3'd0, 25'h7, 25'h9);
    repeat (2) tick();
    chk("busy_ready_low", 32'(cfg_ready), 32'd0);
    repeat (10) tick();
    cfg_valid = 1'b0;
    repeat (20) tick();
    chk("busy_end_idle", 32'(busy), 32'd0);

    // Reset mid-RST with abort high: reset wins
    req(3'd5, 3'd2, 1'b0, 25'h1FFFFFF, 25'h0000001, a);
    tick();
    reset_n = 1'b0;
    abort = 1'b1;
    tick();
    chk("midrst_ctrl", 32'(ctrl_sig), 32'd1);
    chk("midrst_val", 32'(val), 32'd0);
    chk("midrst_want", 32'(wanted_cl_val), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_aborted", 32'(aborted), 32'd0);
    reset_n = 1'b1;
    abort = 1'b0;
    tick();
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    repeat (20) tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcw_sequencer.md
Name: dcw_sequencer

Overview:
- Sequences reconfiguration of the data channel wrapper: takes one configuration request, holds the channel in reset, programs the reference-clock increment pair, waits for the clock to settle, then releases the channel with the selected data width.
- Drives the wrapper's ctrl_sig/val/val1/wanted_cl_val/earlier_cl_val inputs directly.
- Sits between the BERT control registers and the data channel wrapper.

Parameters:
- RESET_CYCLES, 16: cycles ctrl_sig is held at 1 (channel reset) per reconfiguration; legal range 1..255.
- SETTLE_CYCLES, 64: cycles allowed for the reference clock to settle after programming; legal range 1..65535.
- CLW, 25: width of the clock increment values.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- cfg_valid  input  1  request valid.
- cfg_ready  output  1  sequencer can accept a request.
- cfg_width  input  3  primary data width code.
- cfg_alt_width  input  3  alternate data width code.
- cfg_use_alt  input  1  1 = run with the alternate width (ctrl_sig=3); 0 = primary width (ctrl_sig=2).
- cfg_clk_want  input  CLW  wanted reference clock increment.
- cfg_clk_base  input  CLW  base (earlier) clock increment.
- abort  input  1  cancels an in-progress sequence.
- ctrl_sig  output  3  wrapper command: 1 = reset, 2 = run primary, 3 = run alternate.
- val  output  3  primary width to wrapper.
- val1  output  3  alternate width to wrapper.
- wanted_cl_val  output  CLW  to wrapper.
- earlier_cl_val  output  CLW  to wrapper.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse on successful completion.
- aborted  output  1  one-cycle pulse when a sequence is cancelled.

Behaviour:
- Reset (reset_n=0 at an edge) takes effect on that edge, including mid-sequence:
  - state=IDLE, ctrl_sig=1, val=val1=0, wanted_cl_val=earlier_cl_val=0, busy=0, done=0, aborted=0, counter=0.
  - cfg_ready=1 from the first cycle after reset is released.
- Handshake:
  - Accept on the edge where cfg_valid&&cfg_ready.
  - All cfg_* fields are latched into holding registers on accept; inputs may change afterwards.
  - cfg_ready=1 only in IDLE. cfg_valid outside IDLE is ignored and not queued (unless the optional feature is enabled).
- States:
  - IDLE: outputs hold their last values; busy=0. On accept go to RST, clear counter.
  - RST: ctrl_sig=1, val=latched cfg_width, val1=latched cfg_alt_width, busy=1. Count RESET_CYCLES cycles, then go to CLK.
  - CLK (exactly 1 cycle): wanted_cl_val=cfg_clk_want, earlier_cl_val=cfg_clk_base, ctrl_sig stays 1. Then go to SETTLE, clear counter.
  - SETTLE: count SETTLE_CYCLES cycles with ctrl_sig=1, then go to RUN.
  - RUN (1 cycle): ctrl_sig = cfg_use_alt ? 3 : 2, done=1, busy=1. Then go to IDLE; ctrl_sig, val, val1 and clock values stay held.
- Latency from the accept edge to the done cycle is RESET_CYCLES+1+SETTLE_CYCLES+1 cycles. cfg_ready reasserts the cycle after done.
- Counter: sized for max(RESET_CYCLES, SETTLE_CYCLES); compare to parameter-1; no wrap possible.
- cfg_clk_want==cfg_clk_base is legal: values are programmed and SETTLE still runs its full length (the wrapper passes the clock through).
- abort:
  - Sampled in RST, CLK and SETTLE. Next state is IDLE, with aborted=1 for one cycle and ctrl_sig=1 held (channel stays in reset).
  - wanted_cl_val/earlier_cl_val keep whatever was already programmed.
  - abort in IDLE or RUN has no effect; RUN completes and done fires.
- abort coincident with reset_n=0: reset wins, aborted stays 0.
- done and aborted are never both 1.

Optional Feature:
- Macro: DCW_SEQ_PENDING_EN.
- Defined:
  - One-entry pending buffer; cfg_ready=1 whenever the buffer is empty, including while busy.
  - A request accepted while busy is stored and launched on the IDLE cycle after done/aborted: IDLE lasts 1 cycle, then RST.
  - A pending entry survives abort; reset clears it.
- Not defined: pending logic absent; cfg_ready=1 only in IDLE.

Test Plan (RESET_CYCLES=4, SETTLE_CYCLES=8):
- Reset then idle: reset_n low 3 cycles, release -> ctrl_sig=1, val=val1=0, clock values 0, cfg_ready=1, busy=0.
- Basic config: accept width=3'd5, alt=3'd2, use_alt=0, want=25'h100000, base=25'h080000 ->
  - ctrl_sig=1 for 13 cycles; clock values appear at cycle 5 after accept.
  - done at cycle 14 with ctrl_sig=2, val=5, val1=2; cfg_ready=1 at cycle 15.
- Alternate width: same request with use_alt=1 -> done cycle has ctrl_sig=3; ctrl_sig=3 held in IDLE afterwards.
- Abort in SETTLE: assert abort at cycle 8 after accept -> aborted pulse next cycle, no done, ctrl_sig=1, wanted_cl_val=25'h100000 retained, cfg_ready=1.
- Busy rejection: cfg_valid held during a sequence -> cfg_ready=0, no second sequence without DCW_SEQ_PENDING_EN. With the macro, the second request starts RST 2 cycles after the first done.
- Mid-sequence reset: reset_n=0 during RST -> all outputs at reset values next cycle, no done or aborted.
